// File: rtl/ifft_frame_reader_if.sv
// Purpose: bundles the frame-reader handshake, buffer read port and output
// sample stream so the reader and its environment connect through one port.
// Signals:
//   start      environment -> reader   1-cycle pulse, a full frame is buffered
//   busy       reader -> environment   frame in progress
//   raddr      reader -> buffer        read address (combinational read)
//   rdata      buffer -> reader        read data for raddr, same cycle
//   out_valid  reader -> downstream    output sample valid
//   out_ready  downstream -> reader    sample accepted when valid & ready
//   out_re     reader -> downstream    real part (upper half of buffer word)
//   out_im     reader -> downstream    imaginary part (lower half of buffer word)
//   out_idx    reader -> downstream    natural-order index of presented sample
//   out_last   reader -> downstream    marks the sample with out_idx = N-1
//   done       reader -> environment   1-cycle pulse after last acceptance
// Modports: master = reader side, slave = environment/buffer/downstream side.
interface ifft_frame_reader_if #(
    parameter int unsigned DW = 28,
    parameter int unsigned AW = 5
);
    logic              start;
    logic              busy;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DW/2-1:0]   out_re;
    logic [DW/2-1:0]   out_im;
    logic [AW-1:0]     out_idx;
    logic              out_last;
    logic              done;

    modport master (
        input  start,
        input  rdata,
        input  out_ready,
        output busy,
        output raddr,
        output out_valid,
        output out_re,
        output out_im,
        output out_idx,
        output out_last,
        output done
    );

    modport slave (
        output start,
        output rdata,
        output out_ready,
        input  busy,
        input  raddr,
        input  out_valid,
        input  out_re,
        input  out_im,
        input  out_idx,
        input  out_last,
        input  done
    );
endinterface

// File: rtl/ifft_frame_reader.sv
// Purpose: drains one complete N-point frame from the frame buffer per start
// pulse as a valid/ready sample stream, generating the buffer read address
// (natural or bit-reversed order) and re-timing the combinational read data
// into a registered output stage; pulses done after the last acceptance.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    ifft_frame_reader_if.master: start/busy/done handshake, buffer
//          read port (raddr/rdata) and the out_* sample stream
module ifft_frame_reader #(
    parameter int unsigned DW     = 28,
    parameter int unsigned AW     = 5,
    parameter bit          BITREV = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    ifft_frame_reader_if.master   bus
);

    localparam int unsigned HW       = DW / 2;
    localparam int unsigned N        = 1 << AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [AW-1:0]     cnt_q,       cnt_d;
    logic              busy_q,      busy_d;
    logic              out_valid_q, out_valid_d;
    logic [HW-1:0]     out_re_q,    out_re_d;
    logic [HW-1:0]     out_im_q,    out_im_d;
    logic [AW-1:0]     out_idx_q,   out_idx_d;
    logic              out_last_q,  out_last_d;
    logic              done_q,      done_d;

    logic [AW-1:0]     cnt_rev_c;
    logic              load_c;

    // Bit-reversed view of the read counter.
    for (genvar i = 0; i < AW; i++) begin : g_rev
        assign cnt_rev_c[i] = cnt_q[AW-1-i];
    end

    // Address depends only on registered cnt, never on out_ready.
    assign bus.raddr = BITREV ? cnt_rev_c : cnt_q;

    // Output stage may take a new word when empty or being emptied this cycle.
    assign load_c = ~out_valid_q | bus.out_ready;

    // Next-state and output-stage logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            READ: begin
                if (load_c) begin
                    out_re_d    = bus.rdata[DW-1:HW];
                    out_im_d    = bus.rdata[HW-1:0];
                    out_idx_d   = cnt_q;
                    out_last_d  = (cnt_q == LAST_IDX);
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + AW'(1);
                    // Last word loaded; counter wraps to 0 and raddr goes unused.
                    if (cnt_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_ifft_frame_reader.sv
// Bench for ifft_frame_reader: a bit-reversed and a natural-order instance are
// driven with identical start/ready/reset stimulus and each is compared every
// cycle against a transaction-level model of the frame stream.
module tb_ifft_frame_reader;

    localparam int unsigned DW = 28;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 32;
    localparam int          SCN_CYCLES = 200;

    logic clk;
    logic reset;
    logic start;
    logic ready;
    logic [DW-1:0] mem [N];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] perm(input logic [4:0] k, input bit rev);
        return rev ? {k[0], k[1], k[2], k[3], k[4]} : k;
    endfunction

    task automatic fill(input bit rnd);
        for (int k = 0; k < int'(N); k++) begin
            mem[k] = rnd ? 28'($urandom) : {14'(k), 14'(~k)};
        end
    endtask

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit REV = (g == 0);

        ifft_frame_reader_if #(.DW(DW), .AW(AW)) bus ();

        assign bus.start     = start;
        assign bus.out_ready = ready;
        assign bus.rdata     = mem[bus.raddr];

        ifft_frame_reader #(.DW(DW), .AW(AW), .BITREV(REV)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        // Frame-level model: a frame is active from start acceptance until the
        // last of N samples is accepted; samples flow from the 2nd busy cycle.
        logic          m_busy  = 1'b0;
        logic          m_valid = 1'b0;
        logic          m_done  = 1'b0;
        logic [4:0]    m_cnt   = '0;
        logic          acc;
        logic          nb;
        logic [DW-1:0] w;
        string         pfx;
        bit            chk_en  = 1'b0;

        initial pfx = REV ? "br_" : "nat_";

        always @(negedge clk) begin
            if (chk_en) begin
                check_eq({pfx, "busy"},  32'(bus.busy),      32'(m_busy));
                check_eq({pfx, "valid"}, 32'(bus.out_valid), 32'(m_valid));
                check_eq({pfx, "done"},  32'(bus.done),      32'(m_done));
                if (bus.out_valid) begin
                    w = mem[perm(m_cnt, REV)];
                    check_eq({pfx, "idx"},  32'(bus.out_idx),  32'(m_cnt));
                    check_eq({pfx, "re"},   32'(bus.out_re),   32'(w[27:14]));
                    check_eq({pfx, "im"},   32'(bus.out_im),   32'(w[13:0]));
                    check_eq({pfx, "last"}, 32'(bus.out_last), 32'(m_cnt == 5'd31));
                end
            end
            acc = m_valid & ready;
            if (reset) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
                m_done  = 1'b0;
                m_cnt   = '0;
            end else begin
                m_done = acc && (m_cnt == 5'd31);
                nb = m_busy;
                if (!m_busy && start) begin
                    nb    = 1'b1;
                    m_cnt = '0;
                end else if (acc && m_cnt == 5'd31) begin
                    nb = 1'b0;
                end
                if (acc) m_cnt = m_cnt + 5'd1;
                m_valid = m_busy && nb;
                m_busy  = nb;
            end
        end
    end

    // Scenarios: 0 fixed pattern ready=1, 1 random ready/data, 2 stall 5..14,
    // 3 extra start at 10, 4 reset at 12 then start at 20, 5 start on done cycle.
    int exp_done_cyc [6] = '{34, -1, 44, 34, 54, 68};
    int exp_done_n   [6] = '{1, 1, 1, 1, 1, 2};
    int exp_rise_cyc [6] = '{2, 2, 2, 2, 22, 36};

    task automatic run_scn(input int s);
        int  done_n   = 0;
        int  done_cyc = -1;
        int  rise_cyc = -1;
        logic prev_v  = 1'b0;
        for (int c = 0; c < SCN_CYCLES; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (s == 3 && c == 10) || (s == 4 && c == 20) || (s == 5 && c == 34);
            reset = (s == 4 && c == 12);
            case (s)
                1:       ready = 1'($urandom_range(0, 1));
                2:       ready = !(c >= 5 && c < 15);
                default: ready = 1'b1;
            endcase
            @(negedge clk);
            if (g_dut[0].bus.done) begin
                done_n++;
                done_cyc = c;
            end
            if (g_dut[0].bus.out_valid && !prev_v) rise_cyc = c;
            prev_v = g_dut[0].bus.out_valid;
        end
        check_eq($sformatf("scn%0d_done_count", s), 32'(done_n), 32'(exp_done_n[s]));
        check_eq($sformatf("scn%0d_first_valid", s), 32'(rise_cyc), 32'(exp_rise_cyc[s]));
        if (exp_done_cyc[s] >= 0) begin
            check_eq($sformatf("scn%0d_done_cycle", s), 32'(done_cyc), 32'(exp_done_cyc[s]));
        end
        check_eq($sformatf("scn%0d_idle_busy", s), 32'(g_dut[1].bus.busy), 32'd0);
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        fill(1'b0);
        @(posedge clk);
        #1;
        g_dut[0].chk_en = 1'b1;
        g_dut[1].chk_en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_busy",  32'(g_dut[0].bus.busy),      32'd0);
        check_eq("rst_valid", 32'(g_dut[0].bus.out_valid), 32'd0);
        check_eq("rst_last",  32'(g_dut[0].bus.out_last),  32'd0);
        check_eq("rst_done",  32'(g_dut[0].bus.done),      32'd0);
        check_eq("rst_idx",   32'(g_dut[0].bus.out_idx),   32'd0);
        check_eq("rst_re",    32'(g_dut[0].bus.out_re),    32'd0);
        check_eq("rst_im",    32'(g_dut[0].bus.out_im),    32'd0);
        check_eq("rst_raddr", 32'(g_dut[1].bus.raddr),     32'd0);
        reset = 1'b0;

        run_scn(0);
        for (int r = 0; r < 3; r++) begin
            fill(1'b1);
            run_scn(1);
        end
        fill(1'b1);
        run_scn(2);
        fill(1'b0);
        run_scn(3);
        fill(1'b1);
        run_scn(4);
        fill(1'b0);
        run_scn(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
